du_sequencer: RTL and testbench
===============================

Name: du_sequencer

Overview:
Debug-unit controller that sequences the MIPS pipeline from a host byte stream (UART RX/TX side).
- Loads a program word-by-word into instruction memory through the pipeline's du write port.
- Runs the pipeline continuously or one cycle at a time, holds it via the run-enable.
- After a run, streams the register file and a data-memory window back to the host.
- Sits between the UART byte interface and the PIPELINE du_* ports.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words; load address range is 0 to 4*IMEM_WORDS-4.
MEM_DUMP_WORDS, 16, data-memory words dumped after each run, byte addresses 0, 4, ... 4*(MEM_DUMP_WORDS-1).
HALT_WORD, 32'hFC000000, instruction encoding that terminates a load.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_rx_data  in  8  received host byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  8  byte to host
o_tx_valid  out  1  o_tx_data valid; held until accepted
i_tx_ready  in  1  transmitter accepts byte on cycle with o_tx_valid=1 and i_tx_ready=1
o_du_data  out  32  instruction word to write
o_du_inst_addr_wr  out  32  instruction-memory byte address
o_du_write_en  out  1  instruction write strobe
o_du_read_en  out  1  pipeline run-enable (pipeline advances only when 1)
o_du_reg_addr  out  5  register-file read address
o_du_mem_addr  out  8  data-memory read byte address
o_du_reset  out  1  one-cycle pipeline reset pulse
i_du_halt  in  1  pipeline reached HALT
i_du_reg_data  in  32  register read data, valid one cycle after address
i_du_mem_data  in  32  memory read data, valid one cycle after address

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0, load address 0, byte counter 0.
- IDLE, on i_rx_valid, decodes the command byte:
  - 0x4C 'L': go to LOAD.
  - 0x43 'C': go to RUN.
  - 0x53 'S': go to STEP.
  - 0x52 'R': pulse o_du_reset for 1 cycle, reset load address to 0, send 0x06.
  - Any other byte: send NAK 0x15.
- LOAD_BYTE:
  - Shift the received byte in, MSB first.
  - On the 4th byte, go to LOAD_WRITE.
- LOAD_WRITE (1 cycle):
  - Drive o_du_data=word, o_du_inst_addr_wr=address, o_du_write_en=1.
  - Next cycle write_en=0 and address += 4.
  - If word==HALT_WORD: send 0x06, reset address to 0, go to IDLE.
  - Else if the new address == 4*IMEM_WORDS: send 0xEE, reset address to 0, go to IDLE (overflow; no wrap).
  - Else go back to LOAD_BYTE.
- RUN:
  - o_du_read_en=1 each cycle while i_du_halt=0.
  - The first cycle with i_du_halt=1 drops read_en the same cycle (combinational gate) and enters DUMP.
  - If i_du_halt is already 1 on entry, go straight to DUMP with no enable cycle.
- STEP:
  - o_du_read_en=1 for exactly one cycle (none if i_du_halt=1), then DUMP.
- DUMP, per word:
  - SEL: drive the address.
  - LATCH: capture data the next cycle.
  - SEND: send 4 bytes MSB first, each held until handshake.
  - Order is registers 0..31, then memory words 0..MEM_DUMP_WORDS-1.
  - Total 4*(32+MEM_DUMP_WORDS) bytes, then IDLE.
  - o_du_read_en stays 0 throughout.
- Send rules:
  - o_tx_valid asserts the cycle after the byte is chosen.
  - Data is stable while valid=1 and ready=0.
  - Next byte no earlier than the cycle after the accept.
- RX bytes arriving outside IDLE/LOAD_BYTE, including during ACK/NAK sends, are dropped.
- Reset mid-load discards the partial word and leaves memory contents untouched.
- Reset mid-dump truncates the byte stream.

Test Plan:
- 'L', 24 43 FF FF, FC 00 00 00 → write_en pulses at addr 0 data 0x2443FFFF and addr 4 data 0xFC000000; then TX 0x06.
- Load IMEM_WORDS non-halt words → IMEM_WORDS writes; last at addr 4*IMEM_WORDS-4; TX 0xEE; next 'L' writes at addr 0.
- 'C' with halt raised by the model after 10 enabled cycles → read_en high exactly 10 cycles; TX 4*(32+MEM_DUMP_WORDS) bytes; reg 3 = 0x12345678 sends 12 34 56 78 at bytes 12..15.
- 'S' twice → read_en high 1 cycle each; two full dumps; 'S' with halt=1 → read_en never asserted, dump still sent.
- i_tx_ready low 5 cycles mid-dump → o_tx_data/o_tx_valid stable; no byte lost or duplicated.
- 0x7A → TX 0x15. 'R' → o_du_reset 1 cycle, TX 0x06. i_reset during RUN → read_en=0 same cycle, state IDLE.

Source files
------------

// File: rtl/du_sequencer.sv
// rtl/du_sequencer.sv - debug-unit sequencer: host byte commands drive MIPS program load, run/step and state dump
module du_sequencer #(
   parameter int          IMEM_WORDS     = 64,
   parameter int          MEM_DUMP_WORDS = 16,
   parameter logic [31:0] HALT_WORD      = 32'hFC000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [31:0] o_du_data,
   output logic [31:0] o_du_inst_addr_wr,
   output logic        o_du_write_en,
   output logic        o_du_read_en,
   output logic [4:0]  o_du_reg_addr,
   output logic [7:0]  o_du_mem_addr,
   output logic        o_du_reset,
   input  logic        i_du_halt,
   input  logic [31:0] i_du_reg_data,
   input  logic [31:0] i_du_mem_data
);
   localparam int          DUMP_WORDS = 32 + MEM_DUMP_WORDS;
   localparam int          IW         = $clog2(DUMP_WORDS + 1);
   localparam logic [31:0] LOAD_END   = 32'(4 * IMEM_WORDS);
   localparam logic [7:0]  CMD_LOAD = 8'h4C, CMD_RUN = 8'h43, CMD_STEP = 8'h53, CMD_RST = 8'h52;
   localparam logic [7:0]  ACK = 8'h06, NAK = 8'h15, OVF = 8'hEE;

   typedef enum logic [3:0] {
      IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SEL, DUMP_LATCH, DUMP_SEND, TX_WAIT
   } state_t;

   state_t        state, state_nx;
   logic [31:0]   word, addr, dword, addr_nx;
   logic [1:0]    bcnt;
   logic [IW-1:0] idx, mem_idx;
   logic [7:0]    tx_data, send_byte;
   logic          tx_valid, du_reset, send_now;
   logic          tx_accept, dump_last, is_reg, load_done, is_cmd;

   assign tx_accept = tx_valid && i_tx_ready;
   assign dump_last = (idx == IW'(DUMP_WORDS - 1));
   assign is_reg    = (idx < IW'(32));
   assign mem_idx   = idx - IW'(32);
   assign addr_nx   = addr + 32'd4;
   assign load_done = (word == HALT_WORD) || (addr_nx == LOAD_END);
   assign is_cmd    = (i_rx_data == CMD_LOAD) || (i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP);

   assign o_tx_data         = tx_data;
   assign o_tx_valid        = tx_valid;
   assign o_du_data         = word;
   assign o_du_inst_addr_wr = addr;
   assign o_du_reset        = du_reset;
   assign o_du_reg_addr     = is_reg ? idx[4:0] : 5'd0;
   assign o_du_mem_addr     = is_reg ? 8'd0 : 8'({mem_idx, 2'b00});

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (i_rx_valid) begin
            case (i_rx_data)
               CMD_LOAD: state_nx = LOAD_BYTE;
               CMD_RUN:  state_nx = RUN;
               CMD_STEP: state_nx = STEP;
               default:  state_nx = TX_WAIT;
            endcase
         end
         LOAD_BYTE:  if (i_rx_valid && bcnt == 2'd3) state_nx = LOAD_WRITE;
         LOAD_WRITE: state_nx = load_done ? TX_WAIT : LOAD_BYTE;
         RUN:        if (i_du_halt) state_nx = DUMP_SEL;
         STEP:       state_nx = DUMP_SEL;
         DUMP_SEL:   state_nx = DUMP_LATCH;
         DUMP_LATCH: state_nx = DUMP_SEND;
         DUMP_SEND:  if (tx_accept && bcnt == 2'd3) state_nx = dump_last ? IDLE : DUMP_SEL;
         TX_WAIT:    if (tx_accept) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // Run-enable is gated combinationally by halt so the pipeline stops on the halt cycle itself.
   always_comb begin
      o_du_read_en  = 1'b0;
      o_du_write_en = 1'b0;
      send_now      = 1'b0;
      send_byte     = 8'h00;
      case (state)
         IDLE: begin
            send_now  = i_rx_valid && !is_cmd;
            send_byte = (i_rx_data == CMD_RST) ? ACK : NAK;
         end
         LOAD_WRITE: begin
            o_du_write_en = 1'b1;
            send_now      = load_done;
            send_byte     = (word == HALT_WORD) ? ACK : OVF;
         end
         RUN, STEP: o_du_read_en = !i_du_halt;
         DUMP_SEND: begin
            send_now  = !tx_valid;
            send_byte = dword[31:24];
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         word     <= '0;
         addr     <= '0;
         dword    <= '0;
         bcnt     <= '0;
         idx      <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         du_reset <= 1'b0;
      end else begin
         du_reset <= 1'b0;
         if (send_now) begin
            tx_valid <= 1'b1;
            tx_data  <= send_byte;
         end else if (tx_accept) begin
            tx_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               bcnt <= '0;
               idx  <= '0;
               if (i_rx_valid && i_rx_data == CMD_RST) begin
                  du_reset <= 1'b1;
                  addr     <= '0;
               end
            end
            LOAD_BYTE: if (i_rx_valid) begin
               word <= {word[23:0], i_rx_data};
               bcnt <= bcnt + 2'd1;
            end
            LOAD_WRITE: addr <= load_done ? 32'd0 : addr_nx;
            DUMP_LATCH: dword <= is_reg ? i_du_reg_data : i_du_mem_data;
            DUMP_SEND: begin
               if (send_now) dword <= {dword[23:0], 8'h00};
               if (tx_accept) begin
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_du_sequencer.sv
// tb/tb_du_sequencer.sv - scoreboard bench for du_sequencer: load, run, step, dump, handshake stalls, reset
module tb_du_sequencer;
   logic        i_clk = 0, i_reset = 1;
   logic [7:0]  i_rx_data = 0;
   logic        i_rx_valid = 0, i_tx_ready = 1;
   logic        i_du_halt = 0;
   logic [31:0] i_du_reg_data = 0, i_du_mem_data = 0;
   logic [7:0]  o_tx_data, o_du_mem_addr;
   logic        o_tx_valid, o_du_write_en, o_du_read_en, o_du_reset;
   logic [31:0] o_du_data, o_du_inst_addr_wr;
   logic [4:0]  o_du_reg_addr;

   du_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_du_data(o_du_data), .o_du_inst_addr_wr(o_du_inst_addr_wr), .o_du_write_en(o_du_write_en),
      .o_du_read_en(o_du_read_en), .o_du_reg_addr(o_du_reg_addr), .o_du_mem_addr(o_du_mem_addr),
      .o_du_reset(o_du_reset), .i_du_halt(i_du_halt), .i_du_reg_data(i_du_reg_data),
      .i_du_mem_data(i_du_mem_data)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0, failures = 0;
   logic [7:0]  exp_tx[$];
   logic [63:0] exp_wr[$];
   logic [31:0] regs[32];
   logic [31:0] mem[64];
   int          en_cnt = 0, rst_pulses = 0;
   logic        halt_force = 0, halt_arm = 0;
   int          halt_target = 0;
   logic        hold_pending = 0;
   logic [7:0]  hold_data = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Pipeline model: synchronous reg/mem read ports and a halt that can trip after N enabled cycles.
   always @(posedge i_clk) begin
      i_du_reg_data <= regs[o_du_reg_addr];
      i_du_mem_data <= mem[o_du_mem_addr[7:2]];
   end

   always @(posedge i_clk) begin
      #1;
      i_du_halt = halt_force || (halt_arm && en_cnt >= halt_target);
   end

   // Monitor: pops expected TX bytes and writes as the DUT presents them.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_du_read_en) en_cnt++;
         if (o_du_reset) rst_pulses++;
         if (hold_pending) begin
            check("tx_hold_valid", {31'd0, o_tx_valid}, 32'd1);
            check("tx_hold_data", {24'd0, o_tx_data}, {24'd0, hold_data});
         end
         hold_pending = o_tx_valid && !i_tx_ready;
         hold_data    = o_tx_data;
         if (o_tx_valid && i_tx_ready) begin
            if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_tx.pop_front()});
         end
         if (o_du_write_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", o_du_inst_addr_wr, 32'hFFFF_FFFF);
            else begin
               logic [63:0] e;
               e = exp_wr.pop_front();
               check("wr_addr", o_du_inst_addr_wr, e[63:32]);
               check("wr_data", o_du_data, e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic rx(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1;
      tick();
      i_rx_valid = 0;
      tick();
   endtask

   task automatic rx_word(input logic [31:0] w);
      rx(w[31:24]); rx(w[23:16]); rx(w[15:8]); rx(w[7:0]);
   endtask

   task automatic push_dump();
      for (int r = 0; r < 32; r++)
         for (int b = 3; b >= 0; b--) exp_tx.push_back(regs[r][8*b +: 8]);
      for (int m = 0; m < 16; m++)
         for (int b = 3; b >= 0; b--) exp_tx.push_back(mem[m][8*b +: 8]);
   endtask

   task automatic wait_done(input int stall_at);
      int cyc;
      cyc = 0;
      while (exp_tx.size() != 0 || o_tx_valid) begin
         tick();
         cyc++;
         i_tx_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
         if (cyc > 4000) begin
            check("wait_timeout", 32'd1, 32'd0);
            break;
         end
      end
      i_tx_ready = 1;
      repeat (3) tick();
   endtask

   initial begin
      int e0, p0;
      for (int r = 0; r < 32; r++) regs[r] = {8'(r), 8'hA5, 8'(8'hFF - r), 8'(r * 3)};
      regs[0] = 32'h0;
      regs[3] = 32'h1234_5678;
      for (int m = 0; m < 64; m++) mem[m] = 32'hD000_0000 + 32'(m * 32'h0101_0101);

      repeat (3) tick();
      i_reset = 0;
      tick();
      check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("rst_read_en", {31'd0, o_du_read_en}, 32'd0);
      check("rst_write_en", {31'd0, o_du_write_en}, 32'd0);
      check("rst_du_reset", {31'd0, o_du_reset}, 32'd0);
      check("rst_inst_addr", o_du_inst_addr_wr, 32'd0);
      check("rst_du_data", o_du_data, 32'd0);

      // Two-word program terminated by HALT
      exp_wr.push_back({32'd0, 32'h2443_FFFF});
      exp_wr.push_back({32'd4, 32'hFC00_0000});
      exp_tx.push_back(8'h06);
      rx(8'h4C);
      rx_word(32'h2443_FFFF);
      rx_word(32'hFC00_0000);
      wait_done(-1);

      // Fill the whole IMEM without HALT: overflow NAK, no wrap
      for (int i = 0; i < 64; i++) exp_wr.push_back({32'(4 * i), 32'h1000_0000 + 32'(i)});
      exp_tx.push_back(8'hEE);
      rx(8'h4C);
      for (int i = 0; i < 64; i++) rx_word(32'h1000_0000 + 32'(i));
      wait_done(-1);
      exp_wr.push_back({32'd0, 32'hFC00_0000});
      exp_tx.push_back(8'h06);
      rx(8'h4C);
      rx_word(32'hFC00_0000);
      wait_done(-1);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

      // Continuous run, halt after 10 enabled cycles
      e0 = en_cnt;
      halt_target = en_cnt + 10;
      halt_arm = 1;
      push_dump();
      rx(8'h43);
      wait_done(-1);
      check("run_enable_cycles", 32'(en_cnt - e0), 32'd10);
      halt_arm = 0;
      repeat (2) tick();

      // Two single steps, second with a 5-cycle TX stall mid-dump
      e0 = en_cnt;
      push_dump();
      rx(8'h53);
      wait_done(-1);
      check("step1_enable_cycles", 32'(en_cnt - e0), 32'd1);
      e0 = en_cnt;
      push_dump();
      rx(8'h53);
      wait_done(100);
      check("step2_enable_cycles", 32'(en_cnt - e0), 32'd1);

      // Step while already halted: no enable, dump still sent
      halt_force = 1;
      repeat (2) tick();
      e0 = en_cnt;
      push_dump();
      rx(8'h53);
      wait_done(-1);
      check("step_halted_enable", 32'(en_cnt - e0), 32'd0);
      halt_force = 0;
      repeat (2) tick();

      // Unknown command and pipeline reset command
      exp_tx.push_back(8'h15);
      rx(8'h7A);
      wait_done(-1);
      p0 = rst_pulses;
      exp_tx.push_back(8'h06);
      rx(8'h52);
      wait_done(-1);
      check("du_reset_pulse_cycles", 32'(rst_pulses - p0), 32'd1);

      // Async reset during RUN
      rx(8'h43);
      repeat (3) tick();
      check("run_read_en_high", {31'd0, o_du_read_en}, 32'd1);
      i_reset = 1;
      #1;
      check("reset_read_en_low", {31'd0, o_du_read_en}, 32'd0);
      tick();
      i_reset = 0;
      tick();
      check("reset_tx_idle", {31'd0, o_tx_valid}, 32'd0);
      exp_tx.push_back(8'h15);
      rx(8'h7A);
      wait_done(-1);

      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
